mkgauss_prng: RTL and testbench
===============================

Name: mkgauss_prng

Overview:
- ChaCha20-based random source; the transmitter side of the sampler's `r_valid`/`r1`/`r2` interface.
- Expands a 256-bit seed and a 64-bit nonce into a keystream.
- Emits the keystream as pairs of 64-bit words (`r1`, `r2`) with a one-cycle `r_valid` strobe per pair, wired directly into the Gaussian sampler.
- Holds 4 pairs per 512-bit block and regenerates the next block on demand.

Parameters:
- ROUNDS, 20, number of ChaCha rounds; must be even and ≥2; one round per cycle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_valid  in  1  load `seed`/`nonce`, start keystream from counter 0.
- seed  in  256  key; `seed[31:0]` → state word 4 … `seed[255:224]` → word 11.
- nonce  in  64  `nonce[31:0]` → word 14, `nonce[63:32]` → word 15.
- en  in  1  downstream accept-enable; a pair is emitted only in cycles with `en`=1.
- r_valid  out  1  `r1`/`r2` hold a fresh pair this cycle.
- r1  out  64  first random word of pair.
- r2  out  64  second random word of pair.
- busy  out  1  seeded and generating (state ≠ IDLE).
- block_cnt  out  64  ChaCha block counter of the block currently held/being computed.

Behaviour:
- Reset (async, any state): state=IDLE; `r_valid`=0, `r1`=`r2`=0, `busy`=0, `block_cnt`=0; key, nonce and working state cleared.
- State words 0..3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Words 12/13 = `block_cnt` low/high.
- FSM IDLE → ROUND → FINAL → EMIT → ROUND …
  - IDLE: wait for `seed_valid`.
  - ROUND: one round per cycle, 4 quarter-rounds in parallel. Even round index (0-based) = column round, odd = diagonal round. Runs for ROUNDS cycles.
  - FINAL: 1 cycle; out[i] = work[i] + init[i] mod 2^32; result goes to the output buffer.
  - EMIT: pair index k = 0..3; advances only when `en`=1.
    - When `en`=1: `r_valid`=1 for one cycle, `r1` = {w[4k+1], w[4k]}, `r2` = {w[4k+3], w[4k+2]}.
    - `en`=0: `r_valid`=0; `r1`/`r2` hold their last value; k holds.
    - After k=3 is emitted: `block_cnt` increments (64-bit, wraps 0xFFFF_FFFF_FFFF_FFFF→0 silently), then → ROUND for the next block.
- `r_valid` is a registered output; it is never high for two pairs with the same (`block_cnt`, k).
- Latency: `seed_valid` sampled at edge 0 → first `r_valid` at edge ROUNDS+2 when `en`=1 throughout (22 for ROUNDS=20).
- Steady-state spacing with `en`=1: 4 pairs every ROUNDS+5 cycles.
- `seed_valid` in any non-IDLE state (reseed):
  - Aborts the current block or emission; no `r_valid` that cycle.
  - Relatches key/nonce, sets `block_cnt`=0, → ROUND.
  - Pending pairs of the old block are discarded.
- `seed_valid` and `en` in the same cycle: reseed wins; `r_valid`=0.
- `busy`=1 from the cycle after `seed_valid` until reset.

Optional Feature:
- Macro: MKGAUSS_PRNG_DOUBLE_BUF_EN.
- Defined:
  - Adds a second 512-bit output buffer.
  - FINAL writes the back buffer. Computation of block n+1 starts the cycle after block n enters the front buffer, and overlaps emission.
  - The front buffer swaps from the back buffer when pair 3 is emitted and the back buffer is full. Otherwise the FSM waits with `r_valid`=0.
  - `block_cnt` reports the front-buffer block.
  - Spacing with `en`=1: 4 pairs per max(4, ROUNDS+1) cycles.
  - Reseed clears both buffers.
- Undefined: single buffer; behaviour exactly as in Behaviour.

Test Plan:
- Reset: assert `rst` mid-EMIT asynchronously → `r_valid`, `r1`, `r2`, `busy`, `block_cnt` all 0 before the next edge; no `r_valid` until a new `seed_valid`.
- Known vector: `seed`=0, `nonce`=0, `en`=1 → first pair `r1`=0x903df1a0ade0b876, `r2`=0x28bd8653e56a5d40, at edge 22 after seed; `block_cnt`=0.
- Block sequencing: same seed, `en`=1 for 200 cycles → 8 pairs per 2×25 cycles (single-buffer build); `block_cnt` 0→1 after the 4th pair; all 16 words match a software ChaCha20 model.
- Backpressure: toggle `en` 1,0,0,1,… → `r_valid` only in `en`=1 cycles; pair order k=0..3 unbroken; `r1`/`r2` stable while `en`=0.
- Reseed mid-block: `seed_valid` during ROUND cycle 10 with new seed → old block never emitted; first `r_valid` 22 edges later with the new key's block 0.
- Counter wrap: preload `block_cnt`=2^64−1 via `force` → block after it has `block_cnt`=0 and matches the model.

Source files
------------

// File: rtl/mkgauss_prng.sv
// mkgauss_prng: ChaCha keystream source driving the Gaussian sampler r1/r2 port.
// Define MKGAUSS_PRNG_DOUBLE_BUF_EN to overlap next-block compute with emission.
module mkgauss_prng #(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_valid,
    input  logic [255:0] seed,
    input  logic [63:0]  nonce,
    input  logic         en,
    output logic         r_valid,
    output logic [63:0]  r1,
    output logic [63:0]  r2,
    output logic         busy,
    output logic [63:0]  block_cnt
);

    localparam int RW = $clog2(ROUNDS);

    typedef logic [15:0][31:0] blk_t;

    typedef enum logic [2:0] {
        IDLE,
        ROUND,
        FINAL,
        EMIT,
        HOLD
    } state_t;

    function automatic logic [127:0] qr(
        input logic [31:0] a0,
        input logic [31:0] b0,
        input logic [31:0] c0,
        input logic [31:0] d0
    );
        logic [31:0] a, b, c, d, t;
        a = a0 + b0;
        t = d0 ^ a;
        d = {t[15:0], t[31:16]};
        c = c0 + d;
        t = b0 ^ c;
        b = {t[19:0], t[31:20]};
        a = a + b;
        t = d ^ a;
        d = {t[23:0], t[31:24]};
        c = c + d;
        t = b ^ c;
        b = {t[24:0], t[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic blk_t do_round(input blk_t x, input logic diag);
        blk_t y;
        y = x;
        if (!diag) begin
            {y[0], y[4], y[8],  y[12]} = qr(x[0], x[4], x[8],  x[12]);
            {y[1], y[5], y[9],  y[13]} = qr(x[1], x[5], x[9],  x[13]);
            {y[2], y[6], y[10], y[14]} = qr(x[2], x[6], x[10], x[14]);
            {y[3], y[7], y[11], y[15]} = qr(x[3], x[7], x[11], x[15]);
        end else begin
            {y[0], y[5], y[10], y[15]} = qr(x[0], x[5], x[10], x[15]);
            {y[1], y[6], y[11], y[12]} = qr(x[1], x[6], x[11], x[12]);
            {y[2], y[7], y[8],  y[13]} = qr(x[2], x[7], x[8],  x[13]);
            {y[3], y[4], y[9],  y[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        return y;
    endfunction

    function automatic blk_t mk_init(
        input logic [255:0] key,
        input logic [63:0]  non,
        input logic [63:0]  cnt
    );
        blk_t s;
        s[0] = 32'h61707865;
        s[1] = 32'h3320646e;
        s[2] = 32'h79622d32;
        s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
        s[12] = cnt[31:0];
        s[13] = cnt[63:32];
        s[14] = non[31:0];
        s[15] = non[63:32];
        return s;
    endfunction

    function automatic blk_t add_blk(input blk_t a, input blk_t b);
        blk_t s;
        for (int i = 0; i < 16; i++) s[i] = a[i] + b[i];
        return s;
    endfunction

    state_t        state, state_nx;
    logic [RW-1:0] rnd;
    logic [1:0]    k;
    logic [255:0]  key_q;
    logic [63:0]   nonce_q;
    logic [63:0]   ctr;
    blk_t          work, obuf;
    blk_t          init_cur, init_nxt, init_seed, sum;
    logic [63:0]   pair_a, pair_b;
    logic          rnd_last, emit_fire, last;

`ifdef MKGAUSS_PRNG_DOUBLE_BUF_EN
    blk_t          back;
    logic          front_full, back_full, fin, start_next;
    logic [63:0]   comp_cnt;
`endif

    // init words of the block being computed, the next one, and a fresh seed
    assign init_cur  = mk_init(key_q, nonce_q, ctr);
    assign init_nxt  = mk_init(key_q, nonce_q, ctr + 64'd1);
    assign init_seed = mk_init(seed, nonce, 64'd0);
    assign sum       = add_blk(work, init_cur);
    assign rnd_last  = (rnd == RW'(ROUNDS - 1));
    assign pair_a    = {obuf[{k, 2'b01}], obuf[{k, 2'b00}]};
    assign pair_b    = {obuf[{k, 2'b11}], obuf[{k, 2'b10}]};
    assign busy      = (state != IDLE);

`ifdef MKGAUSS_PRNG_DOUBLE_BUF_EN
    assign ctr        = comp_cnt;
    assign fin        = (state == FINAL);
    // pair 3 only leaves once a successor block can take the front slot
    assign emit_fire  = front_full && en && !seed_valid &&
                        (k != 2'd3 || back_full || fin);
    assign last       = emit_fire && (k == 2'd3);
    assign start_next = (fin && (!front_full || last)) ||
                        (state == HOLD && last);
`else
    assign ctr        = block_cnt;
    assign emit_fire  = (state == EMIT) && en && !seed_valid;
    assign last       = emit_fire && (k == 2'd3);
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = IDLE;
            ROUND:   if (rnd_last) state_nx = FINAL;
`ifdef MKGAUSS_PRNG_DOUBLE_BUF_EN
            FINAL:   state_nx = start_next ? ROUND : HOLD;
            HOLD:    if (start_next) state_nx = ROUND;
            EMIT:    state_nx = HOLD;
`else
            FINAL:   state_nx = EMIT;
            EMIT:    if (last) state_nx = ROUND;
            HOLD:    state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
        if (seed_valid) state_nx = ROUND;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rnd       <= '0;
            k         <= '0;
            key_q     <= '0;
            nonce_q   <= '0;
            work      <= '0;
            obuf      <= '0;
            r_valid   <= 1'b0;
            r1        <= '0;
            r2        <= '0;
            block_cnt <= '0;
`ifdef MKGAUSS_PRNG_DOUBLE_BUF_EN
            back       <= '0;
            front_full <= 1'b0;
            back_full  <= 1'b0;
            comp_cnt   <= '0;
`endif
        end else begin
            state   <= state_nx;
            r_valid <= 1'b0;
            if (seed_valid) begin
                key_q     <= seed;
                nonce_q   <= nonce;
                block_cnt <= '0;
                work      <= init_seed;
                rnd       <= '0;
                k         <= '0;
`ifdef MKGAUSS_PRNG_DOUBLE_BUF_EN
                obuf       <= '0;
                back       <= '0;
                front_full <= 1'b0;
                back_full  <= 1'b0;
                comp_cnt   <= '0;
`endif
            end else begin
                if (state == ROUND) begin
                    work <= do_round(work, rnd[0]);
                    rnd  <= rnd_last ? '0 : rnd + 1'b1;
                end
`ifdef MKGAUSS_PRNG_DOUBLE_BUF_EN
                if (fin) begin
                    if (!front_full || last) begin
                        obuf       <= sum;
                        front_full <= 1'b1;
                    end else begin
                        back      <= sum;
                        back_full <= 1'b1;
                    end
                end else if (last) begin
                    obuf      <= back;
                    back_full <= 1'b0;
                end
                if (start_next) begin
                    work     <= init_nxt;
                    comp_cnt <= comp_cnt + 64'd1;
                end
`else
                if (state == FINAL) obuf <= sum;
                if (last) work <= init_nxt;
`endif
                if (emit_fire) begin
                    r_valid <= 1'b1;
                    r1      <= pair_a;
                    r2      <= pair_b;
                    k       <= k + 2'd1;
                end
                if (last) block_cnt <= block_cnt + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_mkgauss_prng.sv
// tb_mkgauss_prng: scoreboard bench for the ChaCha pair source.
// Expected pairs come from a reference ChaCha20 block function.
module tb_mkgauss_prng;

    logic         clk = 1'b0;
    logic         rst;
    logic         seed_valid;
    logic [255:0] seed;
    logic [63:0]  nonce;
    logic         en;
    logic         r_valid;
    logic [63:0]  r1, r2;
    logic         busy;
    logic [63:0]  block_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [63:0] bc;
        logic [63:0] a;
        logic [63:0] b;
    } exp_t;

    exp_t sb[$];

    int qt [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13},
                      '{2, 6, 10, 14}, '{3, 7, 11, 15},
                      '{0, 5, 10, 15}, '{1, 6, 11, 12},
                      '{2, 7, 8, 13}, '{3, 4, 9, 14}};

    mkgauss_prng dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed       (seed),
        .nonce      (nonce),
        .en         (en),
        .r_valid    (r_valid),
        .r1         (r1),
        .r2         (r2),
        .busy       (busy),
        .block_cnt  (block_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_block(
        input logic [255:0] key,
        input logic [63:0]  non,
        input logic [63:0]  ctr,
        input logic [63:0]  bc
    );
        logic [31:0] x  [16];
        logic [31:0] s0 [16];
        exp_t e;
        s0[0] = 32'h61707865;
        s0[1] = 32'h3320646e;
        s0[2] = 32'h79622d32;
        s0[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s0[4+i] = key[32*i +: 32];
        s0[12] = ctr[31:0];
        s0[13] = ctr[63:32];
        s0[14] = non[31:0];
        s0[15] = non[63:32];
        x = s0;
        for (int r = 0; r < 10; r++) begin
            for (int q = 0; q < 8; q++) begin
                int a, b, c, d;
                a = qt[q][0];
                b = qt[q][1];
                c = qt[q][2];
                d = qt[q][3];
                x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 7);
            end
        end
        for (int i = 0; i < 16; i++) x[i] = x[i] + s0[i];
        for (int p = 0; p < 4; p++) begin
            e.bc = (p == 3) ? bc + 64'd1 : bc;
            e.a  = {x[4*p+1], x[4*p]};
            e.b  = {x[4*p+3], x[4*p+2]};
            sb.push_back(e);
        end
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        seed_valid = 1'b0;
        en         = 1'b0;
        seed       = '0;
        nonce      = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic apply_seed(input logic [255:0] kv, input logic [63:0] nv);
        seed       = kv;
        nonce      = nv;
        seed_valid = 1'b1;
        @(posedge clk);
        #1 seed_valid = 1'b0;
    endtask

    task automatic test_reset;
        int seen;
        do_reset;
        @(negedge clk);
        n_cmp++;
        if ({r_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_flags: got %b want 00", {r_valid, busy});
        end
        n_cmp++;
        if ({r1, r2, block_cnt} !== '0) begin
            n_bad++;
            $display("FAIL rst_data: got %h %h %h want 0", r1, r2, block_cnt);
        end
        @(posedge clk);
        #1 en = 1'b1;
        apply_seed(rand_key(), 64'h1234);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_seed: got %b want 1", busy);
        end
        seen = 0;
        for (int e = 0; e < 40 && seen == 0; e++) begin
            @(negedge clk);
            if (r_valid) seen = 1;
        end
        n_cmp++;
        if (seen != 1) begin
            n_bad++;
            $display("FAIL rst_emit_timeout: got %0d want 1", seen);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({r_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL async_rst_flags: got %b want 00", {r_valid, busy});
        end
        n_cmp++;
        if ({r1, r2, block_cnt} !== '0) begin
            n_bad++;
            $display("FAIL async_rst_data: got %h %h %h want 0", r1, r2, block_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (r_valid || busy) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL post_rst_idle: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_known_vector;
        int   at;
        exp_t e;
        do_reset;
        en = 1'b1;
        e.bc = 64'd0;
        e.a  = 64'h903df1a0ade0b876;
        e.b  = 64'h28bd8653e56a5d40;
        sb.push_back(e);
        apply_seed('0, '0);
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            @(negedge clk);
            if (r_valid) at = i;
        end
        n_cmp++;
        if (at != 22) begin
            n_bad++;
            $display("FAIL kv_latency: got %0d want 22", at);
        end
        e = sb.pop_front();
        n_cmp++;
        if (r1 !== e.a) begin
            n_bad++;
            $display("FAIL kv_r1: got %h want %h", r1, e.a);
        end
        n_cmp++;
        if (r2 !== e.b) begin
            n_bad++;
            $display("FAIL kv_r2: got %h want %h", r2, e.b);
        end
        n_cmp++;
        if (block_cnt !== e.bc) begin
            n_bad++;
            $display("FAIL kv_cnt: got %h want %h", block_cnt, e.bc);
        end
    endtask

    task automatic test_blocks;
        logic [255:0] kv;
        logic [63:0]  nv;
        exp_t         e;
        int           np;
        kv = rand_key();
        nv = {$urandom, $urandom};
        do_reset;
        en = 1'b1;
        for (int b = 0; b < 3; b++) push_block(kv, nv, 64'(b), 64'(b));
        apply_seed(kv, nv);
        np = 0;
        for (int t = 0; t < 120 && np < 12; t++) begin
            @(negedge clk);
            if (r_valid) begin
                e = sb.pop_front();
                n_cmp++;
                if (r1 !== e.a || r2 !== e.b) begin
                    n_bad++;
                    $display("FAIL blk_pair%0d: got %h %h want %h %h", np, r1, r2, e.a, e.b);
                end
                n_cmp++;
                if (block_cnt !== e.bc) begin
                    n_bad++;
                    $display("FAIL blk_cnt%0d: got %h want %h", np, block_cnt, e.bc);
                end
                n_cmp++;
                if (t != 22 + 25 * (np / 4) + np % 4) begin
                    n_bad++;
                    $display("FAIL blk_time%0d: got %0d want %0d", np, t, 22 + 25 * (np / 4) + np % 4);
                end
                np++;
            end
        end
        n_cmp++;
        if (np != 12) begin
            n_bad++;
            $display("FAIL blk_count: got %0d want 12", np);
        end
    endtask

    task automatic test_backpressure;
        logic [255:0] kv;
        logic [63:0]  nv, l1, l2;
        exp_t         e;
        logic         en_s;
        int           np, viol, drift;
        kv = rand_key();
        nv = {$urandom, $urandom};
        do_reset;
        push_block(kv, nv, 64'd0, 64'd0);
        push_block(kv, nv, 64'd1, 64'd1);
        apply_seed(kv, nv);
        np = 0; viol = 0; drift = 0;
        l1 = '0; l2 = '0;
        for (int j = 0; j < 300 && np < 8; j++) begin
            @(posedge clk);
            en_s = en;
            #1 en = (j % 3 == 0);
            @(negedge clk);
            if (r_valid) begin
                if (!en_s) viol++;
                e = sb.pop_front();
                n_cmp++;
                if (r1 !== e.a || r2 !== e.b || block_cnt !== e.bc) begin
                    n_bad++;
                    $display("FAIL bp_pair%0d: got %h %h %h want %h %h %h", np, r1, r2, block_cnt, e.a, e.b, e.bc);
                end
                l1 = r1; l2 = r2;
                np++;
            end else if (np > 0 && (r1 !== l1 || r2 !== l2)) begin
                drift++;
            end
        end
        n_cmp++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL bp_valid_no_en: got %0d want 0", viol);
        end
        n_cmp++;
        if (drift != 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d changes want 0", drift);
        end
        n_cmp++;
        if (np != 8) begin
            n_bad++;
            $display("FAIL bp_count: got %0d want 8", np);
        end
    endtask

    task automatic test_reseed;
        logic [255:0] ka, kb, kc;
        logic [63:0]  nb, nc;
        exp_t         e;
        int           at, np;
        ka = rand_key(); kb = rand_key(); kc = rand_key();
        nb = {$urandom, $urandom};
        nc = {$urandom, $urandom};
        do_reset;
        en = 1'b1;
        apply_seed(ka, 64'h55);
        repeat (9) @(posedge clk);
        #1;
        push_block(kb, nb, 64'd0, 64'd0);
        apply_seed(kb, nb);
        at = -1; np = 0;
        for (int t = 0; t < 60 && np < 4; t++) begin
            @(negedge clk);
            if (r_valid) begin
                if (at < 0) at = t;
                e = sb.pop_front();
                n_cmp++;
                if (r1 !== e.a || r2 !== e.b || block_cnt !== e.bc) begin
                    n_bad++;
                    $display("FAIL rs_pair%0d: got %h %h %h want %h %h %h", np, r1, r2, block_cnt, e.a, e.b, e.bc);
                end
                np++;
            end
        end
        n_cmp++;
        if (at != 22) begin
            n_bad++;
            $display("FAIL rs_latency: got %0d want 22", at);
        end
        @(posedge clk);
        #1 en = 1'b0;
        apply_seed(kc, 64'h77);
        repeat (29) @(posedge clk);
        #1 en = 1'b1;
        push_block(kc, nc, 64'd0, 64'd0);
        apply_seed(kc, nc);
        @(negedge clk);
        n_cmp++;
        if (r_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rs_en_clash: got %b want 0", r_valid);
        end
        at = -1; np = 0;
        for (int t = 1; t < 60 && np < 4; t++) begin
            @(negedge clk);
            if (r_valid) begin
                if (at < 0) at = t;
                e = sb.pop_front();
                n_cmp++;
                if (r1 !== e.a || r2 !== e.b || block_cnt !== e.bc) begin
                    n_bad++;
                    $display("FAIL rs2_pair%0d: got %h %h %h want %h %h %h", np, r1, r2, block_cnt, e.a, e.b, e.bc);
                end
                np++;
            end
        end
        n_cmp++;
        if (at != 22) begin
            n_bad++;
            $display("FAIL rs2_latency: got %0d want 22", at);
        end
    endtask

    task automatic test_wrap;
        logic [255:0] kv;
        logic [63:0]  nv;
        exp_t         e;
        int           np;
        kv = rand_key();
        nv = {$urandom, $urandom};
        do_reset;
        apply_seed(kv, nv);
        repeat (29) @(posedge clk);
        #1 force dut.block_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        release dut.block_cnt;
        @(negedge clk);
        n_cmp++;
        if (block_cnt !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_bad++;
            $display("FAIL wrap_preload: got %h want fffffffffffffffe", block_cnt);
        end
        push_block(kv, nv, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        push_block(kv, nv, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        push_block(kv, nv, 64'd0, 64'd0);
        @(posedge clk);
        #1 en = 1'b1;
        np = 0;
        for (int t = 0; t < 150 && np < 12; t++) begin
            @(negedge clk);
            if (r_valid) begin
                e = sb.pop_front();
                n_cmp++;
                if (r1 !== e.a || r2 !== e.b || block_cnt !== e.bc) begin
                    n_bad++;
                    $display("FAIL wrap_pair%0d: got %h %h %h want %h %h %h", np, r1, r2, block_cnt, e.a, e.b, e.bc);
                end
                np++;
            end
        end
        n_cmp++;
        if (np != 12) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d want 12", np);
        end
    endtask

    initial begin
        rst        = 1'b1;
        seed_valid = 1'b0;
        en         = 1'b0;
        seed       = '0;
        nonce      = '0;
        test_reset;
        test_known_vector;
        test_blocks;
        test_backpressure;
        test_reseed;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
